// File: rtl/uart_cmd_decoder_pkg.sv
// Shared constants and types for the UART command decoder.
package uart_cmd_decoder_pkg;
   localparam logic [7:0] ASCII_CR  = 8'h0d;
   localparam logic [7:0] ASCII_0   = 8'h30;
   localparam logic [7:0] CMD_TIME  = 8'h6c;   // 'l'
   localparam logic [7:0] CMD_ALARM = 8'h4c;   // 'L'
   localparam logic [3:0] MAX_TENS  = 4'd5;
   localparam logic [3:0] MAX_ONES  = 4'd9;

   typedef enum logic [1:0] {ST_IDLE, ST_DIG, ST_WCR} state_t;
   typedef enum logic {K_TIME, K_ALARM} kind_t;
endpackage

// File: rtl/uart_cmd_decoder_ascii_bcd_check.sv
// ASCII digit to BCD converter with an upper-bound check ('0'..max).
module ascii_bcd_check
   import uart_cmd_decoder_pkg::*;
(
   input  logic [7:0] i_byte,
   input  logic [3:0] i_max,
   output logic [3:0] o_bcd,
   output logic       o_ok
);
   logic [7:0] w_diff;

   assign w_diff = i_byte - ASCII_0;
   assign o_bcd  = w_diff[3:0];
   assign o_ok   = (i_byte >= ASCII_0) && (w_diff <= {4'h0, i_max});
endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses 'l'/'L' + MMSS + CR frames from the UART byte stream into
// registered time/alarm load pulses; malformed or stalled frames pulse cmd_err.
module uart_cmd_decoder
   import uart_cmd_decoder_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1200,
   parameter int TMO_W       = 11
) (
   input  logic        clk12m,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_data_rdy,
   output logic        ld_time,
   output logic        ld_alarm,
   output logic [15:0] ld_digits,
   output logic        cmd_err,
   output logic        busy
);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);

   state_t           r_state, w_state_nxt;
   kind_t            r_kind, w_kind_nxt;
   logic [1:0]       r_idx, w_idx_nxt;
   logic [3:0][3:0]  r_sh;
   logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
   logic [15:0]      r_digits;
   logic             r_ld_time, r_ld_alarm, r_err;
   logic             w_ld_time, w_ld_alarm, w_err, w_load, w_sh_we;
   logic             w_is_cmd, w_dig_ok;
   kind_t            w_cmd_kind;
   logic [3:0]       w_bcd, w_max;
   logic [1:0]       w_nib;

   assign w_max      = r_idx[0] ? MAX_ONES : MAX_TENS;
   assign w_is_cmd   = (rx_data == CMD_TIME) || (rx_data == CMD_ALARM);
   assign w_cmd_kind = (rx_data == CMD_ALARM) ? K_ALARM : K_TIME;
   // Shadow is packed MSB-first so it maps straight onto ld_digits.
   assign w_nib      = 2'd3 - r_idx;

   ascii_bcd_check u_chk (
      .i_byte (rx_data),
      .i_max  (w_max),
      .o_bcd  (w_bcd),
      .o_ok   (w_dig_ok)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_kind_nxt  = r_kind;
      w_idx_nxt   = r_idx;
      w_ld_time   = 1'b0;
      w_ld_alarm  = 1'b0;
      w_err       = 1'b0;
      w_load      = 1'b0;
      w_sh_we     = 1'b0;
      if (rx_data_rdy) begin
         if (w_is_cmd) begin
            w_state_nxt = ST_DIG;
            w_kind_nxt  = w_cmd_kind;
            w_idx_nxt   = 2'd0;
         end else begin
            case (r_state)
               ST_DIG: begin
                  if (w_dig_ok) begin
                     w_sh_we     = 1'b1;
                     w_idx_nxt   = r_idx + 2'd1;
                     if (r_idx == 2'd3) w_state_nxt = ST_WCR;
                  end else begin
                     w_err       = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end
               end
               ST_WCR: begin
                  w_state_nxt = ST_IDLE;
                  if (rx_data == ASCII_CR) begin
                     w_load     = 1'b1;
                     w_ld_time  = (r_kind == K_TIME);
                     w_ld_alarm = (r_kind == K_ALARM);
                  end else begin
                     w_err = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end else if ((TIMEOUT_CYC > 0) && (r_state != ST_IDLE) && (r_tmo == TMO_LAST)) begin
         w_err       = 1'b1;
         w_state_nxt = ST_IDLE;
      end
   end

   always_comb begin
      w_tmo_nxt = r_tmo;
      if (rx_data_rdy || (r_state == ST_IDLE)) w_tmo_nxt = '0;
      else if (r_tmo != TMO_MAX)               w_tmo_nxt = r_tmo + 1'b1;
   end

   always_ff @(posedge clk12m or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_kind     <= K_TIME;
         r_idx      <= 2'd0;
         r_sh       <= '0;
         r_tmo      <= '0;
         r_digits   <= 16'h0000;
         r_ld_time  <= 1'b0;
         r_ld_alarm <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_kind     <= w_kind_nxt;
         r_idx      <= w_idx_nxt;
         r_tmo      <= w_tmo_nxt;
         r_ld_time  <= w_ld_time;
         r_ld_alarm <= w_ld_alarm;
         r_err      <= w_err;
         if (w_sh_we) r_sh[w_nib] <= w_bcd;
         if (w_load)  r_digits    <= r_sh;
      end
   end

   assign ld_time   = r_ld_time;
   assign ld_alarm  = r_ld_alarm;
   assign cmd_err   = r_err;
   assign ld_digits = r_digits;
   assign busy      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench: stimulus pushes expected pulses, a monitor pops and compares.
module tb_uart_cmd_decoder;
   localparam int TMO = 1200;

   logic        clk12m = 1'b0;
   logic        rst_n  = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_data_rdy = 1'b0;
   logic        ld_time, ld_alarm, cmd_err, busy;
   logic [15:0] ld_digits;

   typedef struct packed {
      logic [2:0]  code;   // {ld_time, ld_alarm, cmd_err}
      logic [15:0] digits;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   logic [15:0] cur_digits = 16'h0000;

   uart_cmd_decoder #(.TIMEOUT_CYC(TMO), .TMO_W(11)) dut (
      .clk12m      (clk12m),
      .rst_n       (rst_n),
      .rx_data     (rx_data),
      .rx_data_rdy (rx_data_rdy),
      .ld_time     (ld_time),
      .ld_alarm    (ld_alarm),
      .ld_digits   (ld_digits),
      .cmd_err     (cmd_err),
      .busy        (busy)
   );

   always #5 clk12m = ~clk12m;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data     = b;
      rx_data_rdy = 1'b1;
      @(posedge clk12m); #1;
      rx_data_rdy = 1'b0;
      rx_data     = 8'hxx;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk12m); #1; end
   endtask

   task automatic expect_ld(input logic alarm, input logic [15:0] d);
      exp_t e;
      e.code   = alarm ? 3'b010 : 3'b100;
      e.digits = d;
      cur_digits = d;
      exp_q.push_back(e);
   endtask

   task automatic expect_err();
      exp_t e;
      e.code   = 3'b001;
      e.digits = cur_digits;
      exp_q.push_back(e);
   endtask

   // Monitor: every cycle with an output pulse must match the queue head.
   always @(negedge clk12m) begin
      if (ld_time || ld_alarm || cmd_err) begin
         exp_t e;
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_pulse: got {time,alarm,err}=%b digits=%h, expected none",
                     {ld_time, ld_alarm, cmd_err}, ld_digits);
         end else begin
            e = exp_q.pop_front();
            check("pulse_kind", {29'd0, ld_time, ld_alarm, cmd_err}, {29'd0, e.code});
            check("pulse_digits", {16'd0, ld_digits}, {16'd0, e.digits});
         end
      end
   end

   initial begin
      idle(3);
      check("rst_ld_time",  {31'd0, ld_time},   32'd0);
      check("rst_ld_alarm", {31'd0, ld_alarm},  32'd0);
      check("rst_cmd_err",  {31'd0, cmd_err},   32'd0);
      check("rst_busy",     {31'd0, busy},      32'd0);
      check("rst_digits",   {16'd0, ld_digits}, 32'd0);
      rst_n = 1'b1;
      idle(2);

      // 1: back-to-back time load, max digits at tens positions
      send("l");
      check("busy_in_frame", {31'd0, busy}, 32'd1);
      send("5"); send("9"); send("5"); send("5");
      expect_ld(1'b0, 16'h5955);
      send(8'h0d);
      idle(3);

      // 2: alarm load after idle gap
      idle(5);
      send("L"); send("0"); send("3"); send("2"); send("4");
      expect_ld(1'b1, 16'h0324);
      send(8'h0d);
      idle(1);
      check("busy_after_load", {31'd0, busy}, 32'd0);
      idle(2);

      // 3: out-of-range tens digit, trailing bytes ignored
      send("l");
      expect_err();
      send("6");
      send("0"); send("0"); send("0"); send(8'h0d);
      idle(2);
      check("busy_after_err", {31'd0, busy}, 32'd0);

      // 4: restart mid-frame switches kind without error
      send("l"); send("1"); send("2");
      send("L"); send("0"); send("1"); send("0"); send("0");
      expect_ld(1'b1, 16'h0100);
      send(8'h0d);
      idle(3);

      // 5: stall times out, then a fresh frame loads
      send("l"); send("1"); send("2");
      expect_err();
      idle(TMO - 2);
      check("busy_before_tmo", {31'd0, busy}, 32'd1);
      idle(5);
      check("busy_after_tmo", {31'd0, busy}, 32'd0);
      check("tmo_fired", exp_q.size(), 32'd0);
      send("l"); send("2"); send("3"); send("4"); send("5");
      expect_ld(1'b0, 16'h2345);
      send(8'h0d);
      idle(3);

      // 6: asynchronous reset mid-frame discards the frame
      send("l"); send("1");
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy",   {31'd0, busy},      32'd0);
      check("arst_digits", {16'd0, ld_digits}, 32'd0);
      check("arst_pulses", {29'd0, ld_time, ld_alarm, cmd_err}, 32'd0);
      idle(2);
      rst_n = 1'b1;
      cur_digits = 16'h0000;
      idle(1);
      send("2"); send("3"); send("4"); send(8'h0d);
      idle(3);
      check("arst_no_load_digits", {16'd0, ld_digits}, 32'd0);
      check("arst_busy_idle",      {31'd0, busy},      32'd0);

      check("queue_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
